// File: rtl/ifetch_bp_cache_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, RV32 opcodes,
// refill FSM states and immediate extraction helpers.
package ifetch_bp_cache_pkg;

    localparam int INST_WID = 32;
    localparam int ADDR_WID = 32;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } fetch_state_e;

    function automatic logic [ADDR_WID-1:0] imm_j(input logic [INST_WID-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [ADDR_WID-1:0] imm_b(input logic [INST_WID-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_bp_cache_bp_bht.sv
// Branch history table of saturating counters: one training port written at
// commit, one combinational lookup port used by fetch.
module ifetch_bp_cache_bp_bht
    import ifetch_bp_cache_pkg::*;
#(
    parameter int BHT_ENTRIES = 256,
    parameter int CTR_W       = 2
) (
    input  logic                           clk,
    input  logic                           rst_ni,
    input  logic                           rdy_i,
    input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx_i,
    output logic                           rd_taken_o,
    input  logic                           upd_en_i,
    input  logic [$clog2(BHT_ENTRIES)-1:0] upd_idx_i,
    input  logic                           upd_taken_i
);

    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;

    logic [CTR_W-1:0] ctr_q [BHT_ENTRIES];
    logic [CTR_W-1:0] upd_cur;

    assign upd_cur    = ctr_q[upd_idx_i];
    // Lookup reads the registered array, so a same-cycle update is not visible.
    assign rd_taken_o = ctr_q[rd_idx_i][CTR_W-1];

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (rdy_i && upd_en_i) begin
            if (upd_taken_i) begin
                if (upd_cur != CTR_MAX) ctr_q[upd_idx_i] <= upd_cur + 1'b1;
            end else begin
                if (upd_cur != '0) ctr_q[upd_idx_i] <= upd_cur - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifetch_bp_cache.sv
// Instruction-fetch stage: direct-mapped I-cache with line refill FSM, BHT
// prediction for conditional branches and static JAL redirect.
module ifetch_bp_cache
    import ifetch_bp_cache_pkg::*;
#(
    parameter int          LINE_INSTS  = 16,
    parameter int          LINES       = 16,
    parameter int          BHT_ENTRIES = 256,
    parameter int          CTR_W       = 2,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         rs_full,
    input  logic                         lsb_full,
    input  logic                         rob_full,
    output logic                         id_en,
    output logic [31:0]                  id_inst,
    output logic [31:0]                  id_pc,
    output logic                         id_pred_taken,
    output logic                         memctrl_en,
    output logic [31:0]                  memctrl_pc,
    input  logic                         memctrl_done,
    input  logic [32*LINE_INSTS-1:0]     memctrl_data,
    input  logic                         rob_set_pc_en,
    input  logic [31:0]                  rob_set_pc,
    input  logic                         rob_bp_en,
    input  logic [31:0]                  rob_bp_pc,
    input  logic                         rob_bp_taken
);

    localparam int WORD_W = $clog2(LINE_INSTS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_WID - OFF_W - IDX_W;
    localparam int BHT_W  = $clog2(BHT_ENTRIES);
    localparam int LINE_W = INST_WID * LINE_INSTS;

    fetch_state_e          state_q;
    logic [ADDR_WID-1:0]   pc_q;
    logic                  valid_q [LINES];
    logic [TAG_W-1:0]      tag_q   [LINES];
    logic [LINE_W-1:0]     data_q  [LINES];

    logic [WORD_W-1:0]     pc_word;
    logic [IDX_W-1:0]      pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [IDX_W-1:0]      fill_idx;
    logic                  fill_we;
    logic                  hit;
    logic                  can_issue;
    logic [INST_WID-1:0]   cur_inst;
    logic                  bht_taken;
    logic [ADDR_WID-1:0]   pc_next_d;
    logic                  pred_d;
    logic                  unused_bits;

    assign pc_word   = pc_q[OFF_W-1:2];
    assign pc_idx    = pc_q[OFF_W+IDX_W-1:OFF_W];
    assign pc_tag    = pc_q[ADDR_WID-1 -: TAG_W];
    assign fill_idx  = memctrl_pc[OFF_W+IDX_W-1:OFF_W];
    assign fill_we   = (state_q == S_WAIT) && memctrl_done;
    assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign cur_inst  = data_q[pc_idx][{pc_word, 5'b0} +: INST_WID];
    // Redirect takes priority over issuing the instruction at the old pc.
    assign can_issue = rdy && !rob_set_pc_en && hit && !rs_full && !lsb_full && !rob_full;

    assign unused_bits = ^{rob_bp_pc[31:BHT_W+2], rob_bp_pc[1:0]};

    ifetch_bp_cache_bp_bht #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CTR_W       (CTR_W)
    ) u_bht (
        .clk         (clk),
        .rst_ni      (rst),
        .rdy_i       (rdy),
        .rd_idx_i    (pc_q[BHT_W+1:2]),
        .rd_taken_o  (bht_taken),
        .upd_en_i    (rob_bp_en),
        .upd_idx_i   (rob_bp_pc[BHT_W+1:2]),
        .upd_taken_i (rob_bp_taken)
    );

    always_comb begin
        pc_next_d = pc_q + 32'd4;
        pred_d    = 1'b0;
        case (cur_inst[6:0])
            OPCODE_JAL: begin
                pc_next_d = pc_q + imm_j(cur_inst);
                pred_d    = 1'b1;
            end
            OPCODE_BRANCH: begin
                if (bht_taken) begin
                    pc_next_d = pc_q + imm_b(cur_inst);
                    pred_d    = 1'b1;
                end
            end
            // Register-indirect target is unknown here; fall through sequentially.
            OPCODE_JALR: pc_next_d = pc_q + 32'd4;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= memctrl_data;
            tag_q[fill_idx]  <= memctrl_pc[ADDR_WID-1 -: TAG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            id_en         <= 1'b0;
            id_inst       <= '0;
            id_pc         <= '0;
            id_pred_taken <= 1'b0;
            memctrl_en    <= 1'b0;
            memctrl_pc    <= '0;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            // Refill completion is captured even while the stage is frozen.
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
                memctrl_en        <= 1'b0;
                state_q           <= S_IDLE;
            end else if (state_q == S_IDLE && rdy && !hit) begin
                memctrl_en <= 1'b1;
                memctrl_pc <= {pc_q[ADDR_WID-1:OFF_W], {OFF_W{1'b0}}};
                state_q    <= S_WAIT;
            end

            id_en <= can_issue;
            if (rdy) begin
                if (rob_set_pc_en) begin
                    pc_q <= rob_set_pc;
                end else if (can_issue) begin
                    pc_q          <= pc_next_d;
                    id_inst       <= cur_inst;
                    id_pc         <= pc_q;
                    id_pred_taken <= pred_d;
                end
            end
        end
    end

endmodule
